// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the controller state type.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result computed at acceptance, held pending,
// and committed to HI/LO after a fixed busy period.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // A zero latency would never leave RUN, so clamp to one cycle.
  localparam int MULT_N = (MULT_CYCLES < 1) ? 1 : MULT_CYCLES;
  localparam int DIV_N  = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;

  mdu_state_e           state_q;
  logic [MDU_CNT_W-1:0] cnt_q;
  logic [MDU_CNT_W-1:0] cnt_d;
  logic [63:0]          pend_q;
  logic [63:0]          result_d;
  logic                 pend_dz_q;
  logic                 dz_d;
  logic [31:0]          hi_q;
  logic [31:0]          lo_q;
  logic                 busy_q;
  logic                 accept;

  assign accept = start && !req && !busy_q;
  assign busy   = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

  always_comb begin
    result_d = '0;
    dz_d     = 1'b0;
    cnt_d    = MDU_CNT_W'(DIV_N);
    case (op)
      MDU_MULT: begin
        result_d = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        cnt_d    = MDU_CNT_W'(MULT_N);
      end
      MDU_MULTU: begin
        result_d = {32'h0, A} * {32'h0, B};
        cnt_d    = MDU_CNT_W'(MULT_N);
      end
      MDU_DIV: begin
        if (B == 32'h0) begin
          dz_d = 1'b1;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          // Most-negative / -1 overflows; wrap the quotient, remainder is 0.
          result_d = {32'h0, 32'h8000_0000};
        end else begin
          result_d = {$signed(A) % $signed(B), $signed(A) / $signed(B)};
        end
      end
      MDU_DIVU: begin
        if (B == 32'h0) begin
          dz_d = 1'b1;
        end else begin
          result_d = {A % B, A / B};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_long_op(op)) begin
              state_q   <= ST_RUN;
              busy_q    <= 1'b1;
              cnt_q     <= cnt_d;
              pend_q    <= result_d;
              pend_dz_q <= dz_d;
            end else if (op == MDU_MTHI) begin
              hi_q <= A;
            end else if (op == MDU_MTLO) begin
              lo_q <= A;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == MDU_CNT_W'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            // Division by zero leaves HI/LO untouched.
            if (!pend_dz_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
          end else begin
            cnt_q <= cnt_q - MDU_CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-indexed reference model with a
// per-cycle compare, plus directed vectors with literal expectations.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  op;
  logic        start;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .req(req), .busy(busy), .HI(HI), .LO(LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: results are due at an absolute cycle index.
  longint      cyc = 0;
  longint      m_done = 0;
  bit          m_busy = 1'b0;
  bit          m_dz = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    longint q;
    longint r;
    cyc++;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (cyc == m_done) begin
        if (!m_dz) {m_hi, m_lo} = m_pend;
        m_busy = 1'b0;
      end
    end else if (start && !req) begin
      m_dz = 1'b0;
      case (op)
        4'd1: begin m_pend = longint'($signed(A)) * longint'($signed(B)); m_busy = 1; m_done = cyc + 5; end
        4'd2: begin m_pend = {32'h0, A} * {32'h0, B}; m_busy = 1; m_done = cyc + 5; end
        4'd3: begin
          if (B == 0) m_dz = 1'b1;
          else begin
            q = longint'($signed(A)) / longint'($signed(B));
            r = longint'($signed(A)) % longint'($signed(B));
            m_pend = {r[31:0], q[31:0]};
          end
          m_busy = 1; m_done = cyc + 10;
        end
        4'd4: begin
          if (B == 0) m_dz = 1'b1;
          else m_pend = {A % B, A / B};
          m_busy = 1; m_done = cyc + 10;
        end
        4'd5: m_hi = A;
        4'd6: m_lo = A;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'h0, busy}, {31'h0, m_busy});
      check("model_hi", HI, m_hi);
      check("model_lo", LO, m_lo);
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
  endtask

  // Counts busy cycles sampled at negedges; bounded so a stuck busy still ends.
  task automatic wait_idle(output int nb);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
      A = $urandom; B = $urandom;
    end
  endtask

  initial begin
    int nb;
    reset = 1'b0; start = 1'b0; req = 1'b0; op = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    reset = 1'b1;

    issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_idle(nb);
    check("mult_busy_cycles", nb, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(nb);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(nb);
    check("div_busy_cycles", nb, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(nb);
    check("div_negdiv_lo", LO, 32'hFFFF_FFFD);
    check("div_negdiv_hi", HI, 32'h0000_0001);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(nb);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(nb);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(MDU_DIVU, 32'd5, 32'd0);
    wait_idle(nb);
    check("divz_busy_cycles", nb, 32'd10);
    check("divz_lo", LO, 32'd3);
    check("divz_hi", HI, 32'd1);

    issue(4'd9, 32'hAAAA_AAAA, 32'h5555_5555);
    check("undef_busy", {31'h0, busy}, 32'h0);
    check("undef_hi", HI, 32'd1);

    issue(MDU_MTHI, 32'h1234_5678, 32'h0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_busy", {31'h0, busy}, 32'h0);
    issue(MDU_MTLO, 32'hCAFE_F00D, 32'h0);
    check("mtlo_lo", LO, 32'hCAFE_F00D);

    // Ignored start and req while busy; in-flight mult must still finish.
    issue(MDU_MULT, 32'd3, 32'd4);
    op = MDU_MTHI; A = 32'hDEAD_BEEF; start = 1'b1; req = 1'b1;
    @(negedge clk);
    op = MDU_MULT; req = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_idle(nb);
    check("ignored_busy_cycles", nb, 32'd3);
    check("ignored_hi", HI, 32'h0);
    check("ignored_lo", LO, 32'd12);
    req = 1'b1; start = 1'b1; op = MDU_MULT; A = 32'd2; B = 32'd2;
    @(negedge clk);
    check("req_blocks_busy", {31'h0, busy}, 32'h0);
    check("req_blocks_lo", LO, 32'd12);
    start = 1'b0; req = 1'b0;

    // Reset in the third busy cycle of a div discards it.
    issue(MDU_DIV, 32'd100, 32'd7);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_hi", HI, 32'h0);
    check("rst_mid_lo", LO, 32'h0);
    reset = 1'b1; start = 1'b1; op = MDU_DIVU; A = 32'd9; B = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_accept", {31'h0, busy}, 32'h1);
    wait_idle(nb);
    check("post_rst_lo", LO, 32'd2);
    check("post_rst_hi", HI, 32'd1);

    // Reset wins over a simultaneous start.
    reset = 1'b0; start = 1'b1; op = MDU_MULT;
    @(negedge clk);
    check("rst_prio_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
